// File: rtl/rom_stream_sink_pkg.sv
// Shared definitions for the cartridge stream sink: FSM states, header byte
// offsets, FLUSH pad byte and the size->address-mask helper.
package rom_stream_sink_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_FLUSH,
    S_DONE,
    S_FAIL
  } state_e;

  localparam int HDR_MAP_CTRL = 21;
  localparam int HDR_ROM_SIZE = 23;
  localparam int HDR_RAM_SIZE = 24;

  localparam logic [7:0] PAD_BYTE = 8'hFF;

  // Shift past bit 23 truncates to zero, so large sizes wrap to 24'hFFFFFF.
  function automatic logic [23:0] size_mask(input logic [7:0] sz);
    return (24'h400 << sz) - 24'd1;
  endfunction

endpackage

// File: rtl/rom_stream_sink.sv
// Cartridge byte-stream sink: strips the copier header, packs payload into
// 16-bit LE words for the ROM controller. Optional payload checksum under ROM_SUM_EN.
module rom_stream_sink
  import rom_stream_sink_pkg::*;
#(
  parameter int HDR_BYTES = 512,
  parameter int MAX_BYTES = 4194304,
  parameter int ADDR_W    = 22
) (
  input  logic              wclk,
  input  logic              resetn,
  input  logic [7:0]        din,
  input  logic              din_valid,
  input  logic              src_loading,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  output logic [7:0]        map_ctrl,
  output logic [3:0]        rom_size,
  output logic [23:0]       rom_mask,
  output logic [23:0]       ram_mask,
  output logic              loading,
  output logic              done,
  output logic              fail,
  output logic [15:0]       rom_sum
);

  localparam int HCNT_W = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
  localparam int PCNT_W = ADDR_W + 1;
  localparam logic [HCNT_W-1:0] HDR_LAST = HCNT_W'(HDR_BYTES - 1);
  localparam logic [PCNT_W-1:0] MAX_CNT  = PCNT_W'(MAX_BYTES);

  state_e              state_q, state_d;
  logic [HCNT_W-1:0]   hdr_idx_q, hdr_idx_d;
  logic [PCNT_W-1:0]   pay_cnt_q, pay_cnt_d;
  logic [7:0]          low_q, low_d;
  logic                low_vld_q, low_vld_d;
  logic                src_q, src_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [15:0]         mem_wdata_q, mem_wdata_d;
  logic [7:0]          map_ctrl_q, map_ctrl_d;
  logic [3:0]          rom_size_q, rom_size_d;
  logic [7:0]          ram_size_q, ram_size_d;
  logic                loading_q, loading_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic                src_fall;
  logic                fail_now;
`ifdef ROM_SUM_EN
  logic [15:0]         sum_q, sum_d;
`endif

  assign src_fall = src_q & ~src_loading;

  always_comb begin
    state_d     = state_q;
    hdr_idx_d   = hdr_idx_q;
    pay_cnt_d   = pay_cnt_q;
    low_d       = low_q;
    low_vld_d   = low_vld_q;
    src_d       = src_loading;
    mem_req_d   = mem_req_q & ~mem_ack;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    map_ctrl_d  = map_ctrl_q;
    rom_size_d  = rom_size_q;
    ram_size_d  = ram_size_q;
    loading_d   = loading_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_now    = 1'b0;
`ifdef ROM_SUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      // hdr_idx_q is still 0 in IDLE, so the first byte lands as index 0.
      S_IDLE, S_HEADER: begin
        if (state_q == S_HEADER && src_fall) begin
          fail_now = 1'b1;
        end else if (din_valid && (state_q == S_HEADER || src_loading)) begin
          loading_d = 1'b1;
          if (hdr_idx_q == HCNT_W'(HDR_MAP_CTRL)) map_ctrl_d = din;
          if (hdr_idx_q == HCNT_W'(HDR_ROM_SIZE)) rom_size_d = din[3:0];
          if (hdr_idx_q == HCNT_W'(HDR_RAM_SIZE)) ram_size_d = din;
          if (hdr_idx_q == HDR_LAST) begin
            state_d = S_PAYLOAD;
          end else begin
            state_d   = S_HEADER;
            hdr_idx_d = hdr_idx_q + 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (din_valid) begin
          if (pay_cnt_q == MAX_CNT) begin
            fail_now = 1'b1;
          end else begin
            pay_cnt_d = pay_cnt_q + 1'b1;
`ifdef ROM_SUM_EN
            sum_d = sum_q + {8'h00, din};
`endif
            if (!low_vld_q) begin
              low_d     = din;
              low_vld_d = 1'b1;
            end else begin
              low_vld_d = 1'b0;
              // Only one word of buffering: the old request must retire this cycle.
              if (mem_req_q && !mem_ack) begin
                fail_now = 1'b1;
              end else begin
                mem_req_d   = 1'b1;
                mem_wdata_d = {din, low_q};
                mem_addr_d  = {pay_cnt_q[ADDR_W-1:1], 1'b0};
              end
            end
          end
        end
        if (!fail_now && src_fall) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (low_vld_q) begin
          if (!mem_req_q || mem_ack) begin
            mem_req_d   = 1'b1;
            mem_wdata_d = {PAD_BYTE, low_q};
            mem_addr_d  = {pay_cnt_q[ADDR_W-1:1], 1'b0};
            low_vld_d   = 1'b0;
          end
        end else if (!mem_req_q) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          loading_d = 1'b0;
        end
      end
      S_DONE, S_FAIL: ;
      default: state_d = S_IDLE;
    endcase
    if (fail_now) begin
      state_d   = S_FAIL;
      mem_req_d = 1'b0;
      loading_d = 1'b0;
      fail_d    = 1'b1;
    end
  end

  always_ff @(posedge wclk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      hdr_idx_q   <= '0;
      pay_cnt_q   <= '0;
      low_q       <= '0;
      low_vld_q   <= 1'b0;
      src_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      map_ctrl_q  <= '0;
      rom_size_q  <= '0;
      ram_size_q  <= '0;
      loading_q   <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      pay_cnt_q   <= pay_cnt_d;
      low_q       <= low_d;
      low_vld_q   <= low_vld_d;
      src_q       <= src_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      map_ctrl_q  <= map_ctrl_d;
      rom_size_q  <= rom_size_d;
      ram_size_q  <= ram_size_d;
      loading_q   <= loading_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
    end
  end

`ifdef ROM_SUM_EN
  always_ff @(posedge wclk) begin
    if (!resetn) sum_q <= '0;
    else         sum_q <= sum_d;
  end
  assign rom_sum = sum_q;
`else
  assign rom_sum = 16'h0;
`endif

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign map_ctrl  = map_ctrl_q;
  assign rom_size  = rom_size_q;
  assign rom_mask  = size_mask({4'h0, rom_size_q});
  assign ram_mask  = size_mask(ram_size_q);
  assign loading   = loading_q;
  assign done      = done_q;
  assign fail      = fail_q;

endmodule

// File: doc/rom_stream_sink.md
# rom_stream_sink

Receiving end of the cartridge byte stream: consumes the byte-serial image produced by a loader (512-byte copier header, then ROM payload), captures the mapping metadata from the header, packs payload bytes into 16-bit little-endian words and issues them as write requests to the ROM memory controller. It sits between any loader source (test or SD-card) and the SDRAM arbiter, and reports load progress and failure to the system core.

## Interface
- HDR_BYTES, 512, header bytes consumed before payload; not written to memory
- MAX_BYTES, 4194304, payload byte limit; exceeding it is a failure
- ADDR_W, 22, byte-address width of mem_addr
- wclk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- din  in  8  stream byte
- din_valid  in  1  one-cycle strobe, din valid; no backpressure to source
- src_loading  in  1  high while source is streaming; falling edge ends the image
- mem_req  out  1  write request, level, held until acknowledged
- mem_addr  out  ADDR_W  byte address of word (bit 0 always 0)
- mem_wdata  out  16  {high byte, low byte}, first payload byte in [7:0]
- mem_ack  in  1  one-cycle acknowledge of current request
- map_ctrl  out  8  header byte 21
- rom_size  out  4  header byte 23 [3:0]
- rom_mask  out  24  (24'h400 << rom_size) - 1
- ram_mask  out  24  (24'h400 << header byte 24) - 1
- loading  out  1  high from first accepted byte until DONE/FAIL
- done  out  1  image fully written
- fail  out  1  sticky error flag
- rom_sum  out  16  payload byte sum (see Configuration)

## Operation
- States: IDLE, HEADER, PAYLOAD, FLUSH, DONE, FAIL.
- IDLE -> HEADER on din_valid with src_loading=1; that byte is header index 0.
- HEADER: header index counter 0..HDR_BYTES-1; latch byte at index 21 to map_ctrl, 23 to rom_size, 24 to ram size register. After index HDR_BYTES-1 -> PAYLOAD.
- PAYLOAD: even payload byte held in low register; odd byte completes word -> load mem_wdata, mem_addr = payload byte offset of the even byte, raise mem_req.
- One word of buffering only: if a word completes while mem_req=1 and mem_ack=0 in that cycle -> FAIL (overrun). Word completion coincident with mem_ack is legal; the new request replaces the old.
- Payload byte count reaching MAX_BYTES+1 -> FAIL; the offending byte is not written.
- src_loading falling edge (registered compare) in PAYLOAD -> FLUSH. In HEADER or IDLE-after-start -> FAIL.
- FLUSH: if an odd byte count left a lone low byte, emit it as a final word with high byte 8'hFF; wait until mem_req drops -> DONE.
- DONE and FAIL are terminal until resetn; din_valid ignored there. FAIL drops mem_req immediately.
- Masks are combinational from latched registers; 24-bit arithmetic, wrap by truncation (rom_size=15 gives 24'hFFFFFF... truncation, defined).

## Timing
- Reset values: mem_req=0, mem_addr=0, mem_wdata=0, map_ctrl=0, rom_size=0, ram size=0 (masks 24'h3FF), loading=0, done=0, fail=0, rom_sum=0, state IDLE.
- mem_req rises the cycle after the odd byte's din_valid; falls the cycle after mem_ack sampled high.
- done/fail rise one cycle after the state transition cycle; loading falls in the same cycle as done/fail rise.
- Reset mid-load: all outputs return to reset values on the next edge; an outstanding mem_req is abandoned.
- Source pacing of one byte every two cycles with controller ack within 2 cycles never overruns.

## Configuration
- ROM_SUM_EN defined: rom_sum accumulates every payload byte (mod 2^16, header excluded, FLUSH pad excluded), final at done.
- Undefined: accumulator removed, rom_sum tied to 16'h0.

## Structure
- Shared package: state enum, header offsets (21, 23, 24), pad byte 8'hFF, mask function (size -> 24-bit mask).
- Single flat module; no sub-module needed.

## Test plan
- 512-byte header with byte21=8'h20, byte23=8'h07, byte24=8'h03, 4 payload bytes 11 22 33 44, immediate ack -> writes (0, 16'h2211), (2, 16'h4433); map_ctrl=8'h20, rom_mask=24'h1FFFF, ram_mask=24'h1FFF; done=1.
- 3 payload bytes AA BB CC -> second write (2, 16'hFFCC) in FLUSH; with ROM_SUM_EN rom_sum=16'h0231.
- Ack withheld 6 cycles, bytes every 2 cycles -> fail=1, mem_req=0, loading=0 after second word completes.
- src_loading drops after 100 header bytes -> fail=1, no mem_req ever raised.
- MAX_BYTES=4, 6 payload bytes -> 2 writes, fail=1 on byte 5.
- resetn low mid-payload with mem_req=1 -> next edge all outputs at reset values; fresh stream then loads correctly.
